cheby_arbiter: RTL and testbench
================================

# cheby_arbiter

Shares one `cheby_BF16` evaluation unit among `N_REQ` independent requesters. Each requester has its own valid/ready request and response channel. The block arbitrates round-robin, holds each grant stable until the unit accepts the operand, and records the requester ID in an in-order tag FIFO. Results are then steered back to their originators. It sits between the per-lane front ends and the single `cheby_BF16` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DEPTH`, default 4: maximum in-flight operations (tag FIFO entries), power of two, ≥2.
- `IDW`, default 2: tag width; must equal clog2(`N_REQ`).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset: `rst==0` at a rising edge resets the block.
- `req_valid`  in  `N_REQ`  per-requester operand valid.
- `req_data`  in  16*`N_REQ`  BF16 operands; requester k uses bits [16k+15:16k].
- `req_ready`  out  `N_REQ`  per-requester accept.
- `resp_valid`  out  `N_REQ`  per-requester result valid; at most one bit set.
- `resp_data`  out  16  BF16 result, shared by all requesters.
- `resp_ready`  in  `N_REQ`  per-requester result accept.
- `u_in_valid`  out  1  to the unit's `in_valid`.
- `u_in_data`  out  16  to the unit's `in_data`.
- `u_in_ready`  in  1  from the unit's `in_ready`.
- `u_out_valid`  in  1  from the unit's `out_valid`.
- `u_out_data`  in  16  from the unit's `out_data`.
- `u_out_ready`  out  1  to the unit's `out_ready`.
- `err`  out  1  sticky protocol error.

## Operation
- **Issue FSM** has two states, IDLE and ISSUE.
- **IDLE**
  - `u_in_valid=0` and all `req_ready=0`.
  - If any `req_valid` is set and the FIFO count < `DEPTH`: choose the winner, register it in `gnt` (IDW bits), go to ISSUE.
  - Winner = first set `req_valid` bit scanning upward from `rr_ptr`, wrapping modulo `N_REQ`.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `u_in_valid=1`, `u_in_data=req_data[gnt]`, `req_ready[gnt]=u_in_ready`; all other `req_ready=0`.
  - On `u_in_ready` (handshake): push `gnt` into the tag FIFO, set `rr_ptr=(gnt+1) mod N_REQ`, go to IDLE.
  - Without `u_in_ready`: hold `gnt` and the data path stable.
  - Requesters must not drop `req_valid` while granted. If `req_valid[gnt]` falls in ISSUE, set `err` and still complete the handshake.
- **Tag FIFO**
  - Circular buffer of `DEPTH` entries with wr_ptr, rd_ptr and a count of width clog2(`DEPTH`)+1.
  - Pointers wrap modulo `DEPTH`.
  - Simultaneous push and pop leaves the count unchanged.
  - Never pushed when full: the IDLE full check guarantees this.
- **Response path** (combinational)
  - When the FIFO is non-empty: `resp_valid[head]=u_out_valid`, `resp_data=u_out_data`, `u_out_ready=resp_ready[head]`.
  - Pop the FIFO when `u_out_valid && u_out_ready`.
  - When the FIFO is empty: `resp_valid=0` and `u_out_ready=0`. If `u_out_valid=1` in that case, set `err`.
  - `resp_data` mirrors `u_out_data` at all times; consumers qualify it with `resp_valid`.
- The unit must be in-order; the block relies on this.

## Timing
- **Reset values:** `req_ready=0`, `resp_valid=0`, `u_in_valid=0`, `u_out_ready=0`, `err=0`. Internal reset: FSM=IDLE, `rr_ptr=0`, `gnt=0`, FIFO pointers and count 0.
- **Issue cadence:** the grant is registered in cycle T (IDLE) and `u_in_valid` asserts in T+1. Peak issue rate is one operation per 2 cycles.
- **Response latency:** 0 added cycles; the result passes through combinationally.
- **Full FIFO:** the FSM stays in IDLE even with requests pending. On the cycle a pop brings count below `DEPTH`, the FSM may grant (count is sampled registered, so the grant comes one cycle after the pop).
- **Reset mid-operation:** all state clears on the reset edge and in-flight tags are discarded. The unit shares `rst` and flushes identically.
- `err` clears only on reset.

## Test plan
1. **Single request, requester 2:** `req_data[2]=16'h3f80`, unit model latency 3.
   - `u_in_valid` rises the cycle after `req_valid[2]`, and `u_in_data=16'h3f80`.
   - `resp_valid=4'b0100` with `resp_data` equal to the model's result; FIFO count returns to 0.
2. **Round-robin:** all 4 requesters hold valid continuously.
   - Grant order is 0,1,2,3,0,1.
   - Responses return in the same order, each with `resp_valid` one-hot to the matching requester.
3. **Full FIFO:** unit out-side stalled (`resp_ready=0`), 5 requests pending.
   - Exactly 4 handshakes occur, then `u_in_valid` stays 0.
   - After one response is accepted, the 5th issues within 2 cycles.
4. **Backpressure on issue:** `u_in_ready=0` for 6 cycles while granted to requester 1.
   - `u_in_data` and `gnt` stay stable, `req_ready[1]=0`, and no other grant occurs.
   - Handshake completes on the cycle `u_in_ready=1`.
5. **Protocol errors:**
   - `u_out_valid=1` with an empty FIFO: `err` goes to 1 next cycle and `resp_valid=0`.
   - Dropping `req_valid[gnt]` in ISSUE also sets `err`.
   - `err` stays 1 until `rst=0`.
6. **Reset mid-flight:** 3 operations outstanding, then `rst=0` for 1 cycle.
   - All outputs return to reset values and count=0.
   - The next request is granted to requester 0 first when all requesters are valid.

Source files
------------

// File: rtl/cheby_arbiter.sv
// cheby_arbiter: round-robin sharing of one cheby_BF16 unit among N_REQ requesters with in-order tag return
module cheby_arbiter #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [15:0]           resp_data,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic                  u_in_valid,
  output logic [15:0]           u_in_data,
  input  logic                  u_in_ready,
  input  logic                  u_out_valid,
  input  logic [15:0]           u_out_data,
  output logic                  u_out_ready,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [IDW-1:0] gnt, rr_ptr, win, k, head;
  logic [IDW-1:0] tags [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, empty;
  // winner is the first valid requester at or above rr_ptr, wrapping; scan downward so the nearest wins
  always_comb begin
    win = rr_ptr;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IDW'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid[k]) win = k;
    end
  end
  // issue side follows the registered grant; response side steers by the FIFO head tag
  always_comb begin
    head = tags[rd_ptr];
    empty = count == '0;
    u_in_valid = state == ISSUE;
    u_in_data = req_data[{gnt, 4'b0000} +: 16];
    req_ready = {N_REQ{u_in_valid & u_in_ready}} & (N_REQ'(1) << gnt);
    push = u_in_valid & u_in_ready;
    resp_valid = {N_REQ{u_out_valid & ~empty}} & (N_REQ'(1) << head);
    resp_data = u_out_data;
    u_out_ready = ~empty & resp_ready[head];
    pop = u_out_valid & u_out_ready;
  end
  // issue FSM, tag FIFO bookkeeping and sticky protocol error
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && |req_valid && count != (AW+1)'(DEPTH)) begin
        gnt <= win;
        state <= ISSUE;
      end else if (push) begin
        state <= IDLE;
        rr_ptr <= gnt == IDW'(N_REQ - 1) ? '0 : gnt + 1'b1;
      end
      if (push) begin
        tags[wr_ptr] <= gnt;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if ((u_out_valid && empty) || (state == ISSUE && !req_valid[gnt])) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cheby_arbiter.sv
// tb_cheby_arbiter: directed scenarios against cheby_arbiter with an in-order latency-3 unit model
module tb_cheby_arbiter;
  logic clk = 0, rst = 0;
  logic [3:0] req_valid = 0, resp_ready = 0, req_ready, resp_valid;
  logic [63:0] req_data = 0;
  logic [15:0] resp_data, u_in_data, u_out_data;
  logic u_in_valid, u_in_ready, u_out_valid, u_out_ready, err;
  logic in_rdy = 1, ovr = 0, ovr_v = 0, mv = 0;
  logic [15:0] md = 0;
  typedef struct {int t; logic [15:0] d;} ent_t;
  ent_t q[$];
  int cyc = 0, total = 0, bad = 0;

  always #5 clk = ~clk;
  assign u_in_ready = in_rdy;
  assign u_out_valid = ovr ? ovr_v : mv;
  assign u_out_data = md;

  cheby_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .u_in_valid(u_in_valid), .u_in_data(u_in_data), .u_in_ready(u_in_ready),
    .u_out_valid(u_out_valid), .u_out_data(u_out_data), .u_out_ready(u_out_ready), .err(err)
  );

  // unit model: result = operand + 16'h0100, valid 3 cycles after acceptance, in order
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) q.delete();
    else begin
      if (u_out_valid && u_out_ready && q.size() > 0) void'(q.pop_front());
      if (u_in_valid && u_in_ready) q.push_back('{cyc + 3, u_in_data + 16'h0100});
    end
    mv <= rst && q.size() > 0 && q[0].t <= cyc;
    md <= q.size() > 0 ? q[0].d : 16'h0;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 0; req_valid = 0; resp_ready = 0; in_rdy = 1; ovr = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic issue_n(input int n, output int got);
    got = 0;
    for (int c = 0; c < 100 && got < n; c++) begin
      @(negedge clk);
      if (u_in_valid && u_in_ready) got++;
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain(output bit ok);
    resp_ready = 4'hf;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      ok = dut.count == 3'd0 && q.size() == 0;
    end
    resp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
    total++; if (resp_valid !== 4'h0) begin bad++; $display("FAIL reset_resp_valid got %h want 0", resp_valid); end
    total++; if (u_in_valid !== 1'b0 || u_out_ready !== 1'b0) begin bad++; $display("FAIL reset_unit got %b%b want 00", u_in_valid, u_out_ready); end
    total++; if (err !== 1'b0 || dut.count !== 3'd0) begin bad++; $display("FAIL reset_err_count got %b/%0d want 0/0", err, dut.count); end
    rst = 1;
  endtask

  task automatic test_single();
    bit ok;
    int w;
    do_reset();
    req_data[47:32] = 16'h3f80;
    req_valid = 4'b0100;
    #1;
    total++; if (u_in_valid !== 1'b0) begin bad++; $display("FAIL single_pre got %b want 0", u_in_valid); end
    @(negedge clk);
    total++; if (u_in_valid !== 1'b1 || u_in_data !== 16'h3f80) begin bad++; $display("FAIL single_issue got %b/%h want 1/3f80", u_in_valid, u_in_data); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 0;
    resp_ready = 4'hf;
    w = 0;
    while (resp_valid === 4'h0 && w < 20) begin @(negedge clk); w++; end
    total++; if (resp_valid !== 4'b0100 || resp_data !== 16'h4080) begin bad++; $display("FAIL single_resp got %b/%h want 0100/4080", resp_valid, resp_data); end
    @(negedge clk);
    total++; if (dut.count !== 3'd0 || err !== 1'b0) begin bad++; $display("FAIL single_count got %0d/%b want 0/0", dut.count, err); end
    drain(ok);
  endtask

  task automatic test_round_robin();
    int g, r;
    bit stop;
    do_reset();
    req_data = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
    req_valid = 4'hf;
    resp_ready = 4'hf;
    g = 0; r = 0; stop = 0;
    for (int c = 0; c < 80 && (g < 6 || r < 6); c++) begin
      @(negedge clk);
      if (stop) req_valid = 0;
      if (u_in_valid && u_in_ready && g < 6) begin
        total++; if (req_ready !== 4'b1 << (g % 4) || u_in_data !== 16'h4000 + 16'(g % 4)) begin bad++; $display("FAIL rr_grant%0d got %b/%h want req %0d", g, req_ready, u_in_data, g % 4); end
        g++;
        stop = g == 6;
      end
      if (resp_valid !== 4'h0 && r < 6) begin
        total++; if (resp_valid !== 4'b1 << (r % 4) || resp_data !== 16'h4100 + 16'(r % 4)) begin bad++; $display("FAIL rr_resp%0d got %b/%h want req %0d", r, resp_valid, resp_data, r % 4); end
        r++;
      end
    end
    total++; if (g != 6 || r != 6) begin bad++; $display("FAIL rr_timeout got %0d/%0d want 6/6", g, r); end
    resp_ready = 0;
  endtask

  task automatic test_full();
    int hs;
    bit ok, found;
    do_reset();
    req_data = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
    req_valid = 4'hf;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (u_in_valid && u_in_ready) hs++;
    end
    total++; if (hs != 4 || u_in_valid !== 1'b0 || dut.count !== 3'd4) begin bad++; $display("FAIL full_stall got %0d/%b/%0d want 4/0/4", hs, u_in_valid, dut.count); end
    resp_ready = 4'b0001;
    #1;
    total++; if (resp_valid !== 4'b0001 || resp_data !== 16'h4100 || u_out_ready !== 1'b1) begin bad++; $display("FAIL full_pop got %b/%h/%b want 0001/4100/1", resp_valid, resp_data, u_out_ready); end
    @(negedge clk);
    resp_ready = 0;
    found = 0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge clk);
      found = u_in_valid && u_in_ready;
    end
    total++; if (!found || req_ready !== 4'b0001) begin bad++; $display("FAIL full_fifth got %b/%b want 1/0001", found, req_ready); end
    @(negedge clk);
    req_valid = 0;
    total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL full_refill got %0d want 4", dut.count); end
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL full_drain got %0d want 0", dut.count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    in_rdy = 0;
    req_data[31:16] = 16'h1234;
    req_valid = 4'b1010;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      total++; if ({u_in_valid, u_in_data, dut.gnt, req_ready} !== {1'b1, 16'h1234, 2'd1, 4'h0}) begin bad++; $display("FAIL bp_hold%0d got %b/%h/%0d/%b want 1/1234/1/0000", i, u_in_valid, u_in_data, dut.gnt, req_ready); end
    end
    in_rdy = 1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 0;
    total++; if (u_in_valid !== 1'b0 || dut.count !== 3'd1) begin bad++; $display("FAIL bp_done got %b/%0d want 0/1", u_in_valid, dut.count); end
    drain(ok);
  endtask

  task automatic test_errors();
    bit ok;
    do_reset();
    ovr = 1; ovr_v = 1;
    #1;
    total++; if (resp_valid !== 4'h0 || u_out_ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL err_empty_pre got %b/%b/%b want 0000/0/0", resp_valid, u_out_ready, err); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_empty got %b want 1", err); end
    ovr = 0;
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", err); end
    in_rdy = 0;
    req_valid = 4'b0001;
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_drop_pre got %b want 0", err); end
    req_valid = 0;
    @(negedge clk);
    total++; if (err !== 1'b1 || u_in_valid !== 1'b1) begin bad++; $display("FAIL err_drop got %b/%b want 1/1", err, u_in_valid); end
    in_rdy = 1;
    @(negedge clk);
    total++; if (u_in_valid !== 1'b0 || dut.count !== 3'd1) begin bad++; $display("FAIL err_drop_hs got %b/%0d want 0/1", u_in_valid, dut.count); end
    drain(ok);
    total++; if (err !== 1'b1 || !ok) begin bad++; $display("FAIL err_hold got %b/%b want 1/1", err, ok); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_reclear got %b want 0", err); end
  endtask

  task automatic test_mid_reset();
    int got;
    bit ok;
    do_reset();
    req_data = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
    req_valid = 4'hf;
    issue_n(3, got);
    total++; if (got != 3 || dut.count !== 3'd3) begin bad++; $display("FAIL mid_inflight got %0d/%0d want 3/3", got, dut.count); end
    rst = 0;
    @(negedge clk);
    rst = 1;
    #1;
    total++; if ({u_in_valid, req_ready, resp_valid, u_out_ready, err} !== 11'b0 || dut.count !== 3'd0) begin bad++; $display("FAIL mid_reset got %b%b%b%b%b/%0d want 0/0", u_in_valid, req_ready, resp_valid, u_out_ready, err, dut.count); end
    req_valid = 4'hf;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 0;
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_drain got %0d want 0", dut.count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_backpressure();
    test_errors();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
